// File: rtl/mac_seq_ctrl_if.sv
// Bus bundle between the MAC sequencer and its environment (memories, MAC, result sink).
// master : the sequencer side (drives addresses, MAC operands, status and results)
// slave  : the environment side (drives start, memory read data and the MAC sum)
interface mac_seq_ctrl_if #(
  parameter int PADDR_W = 6,
  parameter int WADDR_W = 9,
  parameter int ACC_W   = 26,
  parameter int NIDX_W  = 4
);
  logic               start;
  logic               busy;
  logic               done;
  logic [PADDR_W-1:0] pix_addr;
  logic [WADDR_W-1:0] wgt_addr;
  logic [127:0]       pix_data;
  logic [127:0]       wgt_data;
  logic [127:0]       mac_pixels;
  logic [127:0]       mac_weights;
  logic [19:0]        mac_sum;
  logic               result_valid;
  logic [NIDX_W-1:0]  result_idx;
  logic [ACC_W-1:0]   result_acc;
  logic [NIDX_W-1:0]  digit_out;

  modport master (
    input  start, pix_data, wgt_data, mac_sum,
    output busy, done, pix_addr, wgt_addr, mac_pixels, mac_weights,
           result_valid, result_idx, result_acc, digit_out
  );

  modport slave (
    output start, pix_data, wgt_data, mac_sum,
    input  busy, done, pix_addr, wgt_addr, mac_pixels, mac_weights,
           result_valid, result_idx, result_acc, digit_out
  );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Sequencer for a 16-lane 8-bit MAC pipeline. Streams NUM_CHUNKS pixel/weight words
// per neuron from synchronous memories into the MAC, accumulates the MAC sums into one
// dot product per neuron and tracks the argmax over NUM_NEURONS neurons.
// Ports: clk, rst (async, active high), bus (mac_seq_ctrl_if.master):
//   start/busy/done frame handshake, pix_addr/wgt_addr memory addresses,
//   pix_data/wgt_data memory data, mac_pixels/mac_weights/mac_sum MAC link,
//   result_valid/result_idx/result_acc per-neuron result, digit_out predicted digit.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | one chunk address per cycle for the current neuron
// DRAIN | all chunks issued, waiting for the tagged last sum
// NEXT  | final neuron result pulsing, argmax compare in progress
// FIN   | done pulse, digit_out valid
module mac_seq_ctrl #(
  parameter int NUM_CHUNKS  = 49,
  parameter int NUM_NEURONS = 10,
  parameter int PADDR_W     = 6,
  parameter int WADDR_W     = 9,
  parameter int ACC_W       = 26,
  parameter int NIDX_W      = 4
) (
  input  logic           clk,
  input  logic           rst,
  mac_seq_ctrl_if.master bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, NEXT, FIN} state_t;

  state_t             state, state_nxt;
  logic [PADDR_W-1:0] chunk;
  logic [WADDR_W-1:0] waddr;
  logic [NIDX_W-1:0]  neuron;
  logic [3:0]         tag_v, tag_f, tag_l;
  logic [ACC_W-1:0]   acc, acc_nxt, res_acc, best;
  logic               res_valid;
  logic [NIDX_W-1:0]  res_idx, digit;
  logic               issue, last_chunk, last_neuron, sum_last;
  logic               busy_c, done_c;

  assign last_chunk  = (chunk == PADDR_W'(NUM_CHUNKS - 1));
  assign last_neuron = (neuron == NIDX_W'(NUM_NEURONS - 1));
  assign issue       = (state == ISSUE);
  assign sum_last    = tag_v[3] & tag_l[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Between neurons DRAIN returns straight to ISSUE so the next neuron's first
  // address lines up with the previous neuron's result pulse.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = ISSUE;
      ISSUE:   if (last_chunk) state_nxt = DRAIN;
      DRAIN:   if (sum_last) state_nxt = last_neuron ? NEXT : ISSUE;
      NEXT:    state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_c = (state == ISSUE) || (state == DRAIN) || (state == NEXT);
    done_c = (state == FIN);
  end

  // chunk doubles as pix_addr; waddr runs continuously across neurons so it
  // equals neuron*NUM_CHUNKS + chunk without a multiplier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chunk  <= '0;
      waddr  <= '0;
      neuron <= '0;
    end else if (state == IDLE && bus.start) begin
      chunk  <= '0;
      waddr  <= '0;
      neuron <= '0;
    end else if (issue && !last_chunk) begin
      chunk <= chunk + 1'b1;
      waddr <= waddr + 1'b1;
    end else if (state == DRAIN && sum_last && !last_neuron) begin
      chunk  <= '0;
      waddr  <= waddr + 1'b1;
      neuron <= neuron + 1'b1;
    end
  end

  // Tag stage 3 lines up with mac_sum for the address issued four cycles earlier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v <= '0;
      tag_f <= '0;
      tag_l <= '0;
    end else begin
      tag_v <= {tag_v[2:0], issue};
      tag_f <= {tag_f[2:0], issue && (chunk == '0)};
      tag_l <= {tag_l[2:0], issue && last_chunk};
    end
  end

  always_comb begin
    if (tag_f[3]) acc_nxt = {{(ACC_W-20){1'b0}}, bus.mac_sum};
    else          acc_nxt = acc + {{(ACC_W-20){1'b0}}, bus.mac_sum};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      res_valid <= 1'b0;
      res_acc   <= '0;
      res_idx   <= '0;
    end else begin
      res_valid <= sum_last;
      if (tag_v[3]) acc <= acc_nxt;
      if (sum_last) begin
        res_acc <= acc_nxt;
        res_idx <= neuron;
      end
    end
  end

  // Strict compare keeps the lower index on ties; neuron 0 always seeds the search.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best  <= '0;
      digit <= '0;
    end else if (res_valid && (res_idx == '0 || res_acc > best)) begin
      best  <= res_acc;
      digit <= res_idx;
    end
  end

  assign bus.busy         = busy_c;
  assign bus.done         = done_c;
  assign bus.pix_addr     = chunk;
  assign bus.wgt_addr     = waddr;
  assign bus.mac_pixels   = bus.pix_data;
  assign bus.mac_weights  = bus.wgt_data;
  assign bus.result_valid = res_valid;
  assign bus.result_idx   = res_idx;
  assign bus.result_acc   = res_acc;
  assign bus.digit_out    = digit;
endmodule

// File: tb/tb_mac_seq_ctrl.sv
module tb_mac_seq_ctrl;
  localparam int NC = 49;
  localparam int NN = 10;
  localparam int PER = NC + 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mac_seq_ctrl_if #(.PADDR_W(6), .WADDR_W(9), .ACC_W(26), .NIDX_W(4)) bus ();

  mac_seq_ctrl #(
    .NUM_CHUNKS(NC), .NUM_NEURONS(NN), .PADDR_W(6), .WADDR_W(9), .ACC_W(26), .NIDX_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment: synchronous memories and a 3-stage MAC without reset.
  logic [127:0] pix_mem [64];
  logic [127:0] wgt_mem [512];
  logic [19:0]  s1, s2, s3;

  function automatic logic [19:0] mac16(input logic [127:0] p, input logic [127:0] w);
    logic [19:0] s;
    s = '0;
    for (int l = 0; l < 16; l++) s = s + 20'(p[8*l +: 8]) * 20'(w[8*l +: 8]);
    return s;
  endfunction

  always @(posedge clk) begin
    bus.pix_data <= pix_mem[bus.pix_addr];
    bus.wgt_data <= wgt_mem[bus.wgt_addr];
    s1 <= mac16(bus.mac_pixels, bus.mac_weights);
    s2 <= s1;
    s3 <= s2;
  end
  assign bus.mac_sum = s3;

  // Reference results and per-frame observation log.
  longint exp_acc [NN];
  int     exp_digit;
  int     pa [701];
  int     wa [701];
  longint res_acc [16];
  int     res_idx [16];
  int     res_cyc [16];
  int     nres, ndone, done_cyc, busy1, busy_at_done, digit_at_done;

  task automatic fill(input int mode);
    logic [7:0] b;
    for (int c = 0; c < 64; c++)
      for (int l = 0; l < 16; l++) begin
        case (mode)
          2:       b = 8'hFF;
          3:       b = 8'($urandom);
          default: b = 8'd1;
        endcase
        pix_mem[c][8*l +: 8] = b;
      end
    for (int a = 0; a < 512; a++)
      for (int l = 0; l < 16; l++) begin
        case (mode)
          1:       b = (a / NC == 7) ? 8'd2 : 8'd1;
          2:       b = 8'hFF;
          3:       b = 8'($urandom);
          4:       b = (a / NC == 3 || a / NC == 5) ? 8'd3 : 8'($urandom_range(0, 2));
          default: b = 8'd1;
        endcase
        wgt_mem[a][8*l +: 8] = b;
      end
  endtask

  task automatic compute_expected();
    longint s;
    longint top;
    top = -1;
    for (int n = 0; n < NN; n++) begin
      s = 0;
      for (int c = 0; c < NC; c++)
        for (int l = 0; l < 16; l++)
          s += longint'(pix_mem[c][8*l +: 8]) * longint'(wgt_mem[n*NC + c][8*l +: 8]);
      exp_acc[n] = s;
      if (s > top) begin
        top = s;
        exp_digit = n;
      end
    end
  endtask

  // Pulses start, then logs outputs once per cycle (cycle 1 = first cycle after the
  // start edge). extra_start>0 injects a second start pulse during that cycle.
  task automatic run_frame(input int extra_start);
    nres = 0; ndone = 0; done_cyc = -1; busy1 = -1; busy_at_done = -1; digit_at_done = -1;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    for (int k = 1; k <= 700; k++) begin
      if (k > 1) @(negedge clk);
      bus.start = (k == extra_start);
      pa[k] = int'(bus.pix_addr);
      wa[k] = int'(bus.wgt_addr);
      if (k == 1) busy1 = int'(bus.busy);
      if (bus.result_valid && nres < 16) begin
        res_acc[nres] = longint'(bus.result_acc);
        res_idx[nres] = int'(bus.result_idx);
        res_cyc[nres] = k;
        nres++;
      end
      if (bus.done) begin
        if (ndone == 0) begin
          done_cyc = k;
          busy_at_done = int'(bus.busy);
          digit_at_done = int'(bus.digit_out);
        end
        ndone++;
      end
      if (done_cyc > 0 && k >= done_cyc + 5) break;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0d exp=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0d exp=0", bus.done); end
    total++; if (bus.pix_addr !== '0) begin bad++; $display("FAIL reset_pix_addr got=%0d exp=0", bus.pix_addr); end
    total++; if (bus.wgt_addr !== '0) begin bad++; $display("FAIL reset_wgt_addr got=%0d exp=0", bus.wgt_addr); end
    total++; if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0d exp=0", bus.result_valid); end
    total++; if (bus.result_acc !== '0) begin bad++; $display("FAIL reset_acc got=%0d exp=0", bus.result_acc); end
    total++; if (bus.result_idx !== '0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", bus.result_idx); end
    total++; if (bus.digit_out !== '0) begin bad++; $display("FAIL reset_digit got=%0d exp=0", bus.digit_out); end
  endtask

  task automatic test_frame(input int mode, input string name);
    fill(mode);
    compute_expected();
    run_frame(0);
    total++; if (nres != NN) begin bad++; $display("FAIL %s_count got=%0d exp=%0d", name, nres, NN); end
    for (int n = 0; n < nres && n < NN; n++) begin
      total++; if (res_acc[n] != exp_acc[n]) begin bad++; $display("FAIL %s_acc%0d got=%0d exp=%0d", name, n, res_acc[n], exp_acc[n]); end
      total++; if (res_idx[n] != n) begin bad++; $display("FAIL %s_idx%0d got=%0d exp=%0d", name, n, res_idx[n], n); end
    end
    total++; if (ndone != 1) begin bad++; $display("FAIL %s_done_count got=%0d exp=1", name, ndone); end
    total++; if (digit_at_done != exp_digit) begin bad++; $display("FAIL %s_digit got=%0d exp=%0d", name, digit_at_done, exp_digit); end
  endtask

  task automatic test_timing();
    fill(3);
    compute_expected();
    run_frame(100);
    total++; if (busy1 != 1) begin bad++; $display("FAIL timing_busy_rise got=%0d exp=1", busy1); end
    total++; if (nres != NN) begin bad++; $display("FAIL timing_count got=%0d exp=%0d", nres, NN); end
    for (int n = 0; n < nres && n < NN; n++) begin
      total++; if (res_cyc[n] != 1 + PER + n*PER) begin bad++; $display("FAIL timing_valid_cycle%0d got=%0d exp=%0d", n, res_cyc[n], 1 + PER + n*PER); end
      total++; if (res_acc[n] != exp_acc[n]) begin bad++; $display("FAIL timing_acc%0d got=%0d exp=%0d", n, res_acc[n], exp_acc[n]); end
    end
    total++; if (done_cyc != NN*PER + 2) begin bad++; $display("FAIL timing_done_cycle got=%0d exp=%0d", done_cyc, NN*PER + 2); end
    total++; if (ndone != 1) begin bad++; $display("FAIL timing_second_start got=%0d done pulses exp=1", ndone); end
    total++; if (busy_at_done != 0) begin bad++; $display("FAIL timing_busy_at_done got=%0d exp=0", busy_at_done); end
    total++; if (digit_at_done != exp_digit) begin bad++; $display("FAIL timing_digit got=%0d exp=%0d", digit_at_done, exp_digit); end
    for (int n = 0; n < NN; n++)
      for (int c = 0; c < NC; c++) begin
        total++; if (pa[1 + n*PER + c] != c) begin bad++; $display("FAIL timing_pix_addr n%0d c%0d got=%0d exp=%0d", n, c, pa[1 + n*PER + c], c); end
        total++; if (wa[1 + n*PER + c] != n*NC + c) begin bad++; $display("FAIL timing_wgt_addr n%0d c%0d got=%0d exp=%0d", n, c, wa[1 + n*PER + c], n*NC + c); end
      end
  endtask

  task automatic test_reset_mid();
    fill(1);
    compute_expected();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (4*PER + 20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%0d exp=0", bus.busy); end
    total++; if (bus.pix_addr !== '0) begin bad++; $display("FAIL midrst_pix_addr got=%0d exp=0", bus.pix_addr); end
    total++; if (bus.wgt_addr !== '0) begin bad++; $display("FAIL midrst_wgt_addr got=%0d exp=0", bus.wgt_addr); end
    total++; if (bus.result_acc !== '0) begin bad++; $display("FAIL midrst_acc got=%0d exp=0", bus.result_acc); end
    total++; if (bus.result_idx !== '0) begin bad++; $display("FAIL midrst_idx got=%0d exp=0", bus.result_idx); end
    total++; if (bus.result_valid !== 1'b0 || bus.done !== 1'b0) begin bad++; $display("FAIL midrst_pulses got=%0d%0d exp=00", bus.result_valid, bus.done); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_frame(0);
    total++; if (nres != NN) begin bad++; $display("FAIL midrst_count got=%0d exp=%0d", nres, NN); end
    for (int n = 0; n < nres && n < NN; n++) begin
      total++; if (res_acc[n] != exp_acc[n]) begin bad++; $display("FAIL midrst_acc%0d got=%0d exp=%0d", n, res_acc[n], exp_acc[n]); end
    end
    total++; if (digit_at_done != exp_digit) begin bad++; $display("FAIL midrst_digit got=%0d exp=%0d", digit_at_done, exp_digit); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    for (int c = 0; c < 64; c++) pix_mem[c] = '0;
    for (int a = 0; a < 512; a++) wgt_mem[a] = '0;
    test_reset();
    test_frame(0, "ones");
    test_frame(1, "neuron7");
    test_frame(2, "saturated");
    test_timing();
    test_frame(4, "tie");
    test_reset_mid();
    test_frame(3, "random_a");
    test_frame(3, "random_b");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
